// File: rtl/acc_pkg.sv
// Shared accelerator types: fp16 pixel and the 9-tap window bundle that the
// window generator, adder tree and MAC array exchange.
package acc_pkg;

  localparam int DATA_W   = 16;
  localparam int WIN_TAPS = 9;

  typedef logic [15:0] fp16_t;
  typedef fp16_t [8:0] win9_t;

endpackage

// File: rtl/line_buffer_fp16.sv
// One-row line buffer: single address, combinational read of the old word,
// write of the new word on the same clock edge (read-before-write).
// Contents are deliberately not reset; the consumer masks stale rows.
module line_buffer_fp16
  import acc_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  // Store the incoming word at the current column when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_gen_fp16.sv
// Streaming 3x3 sliding-window generator. Pixels arrive in raster order,
// two line buffers supply the rows above, and a single output register
// presents each complete window with a valid/ready handshake.
module window3x3_gen_fp16
  import acc_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = acc_pkg::DATA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_sof,
  output logic                              win_valid,
  input  logic                              win_ready,
  output logic [WIN_TAPS-1:0][DATA_W-1:0]   win_data,
  output logic                              win_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef logic [WIN_TAPS-1:0][DATA_W-1:0] win_t;

  logic [RW-1:0]     row_q, row_d, cur_row_s;
  logic [CW-1:0]     col_q, col_d, cur_col_s;
  win_t              win_q, win_d;
  win_t              out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              accept_s, load_s;
  logic [DATA_W-1:0] lb0_rd_s, lb1_rd_s;

  // One output stage: a new pixel is taken whenever the held window leaves.
  assign in_ready = !out_valid_q || win_ready;
  assign accept_s = in_valid && in_ready;

  // lb0 holds the previous row; lb1 holds the row before that.
  line_buffer_fp16 #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (cur_col_s),
    .wdata (in_data),
    .rdata (lb0_rd_s)
  );

  line_buffer_fp16 #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (cur_col_s),
    .wdata (lb0_rd_s),
    .rdata (lb1_rd_s)
  );

  // Position of the pixel on the input bus; start-of-frame forces (0,0).
  always_comb begin
    if (in_sof) begin
      cur_row_s = '0;
      cur_col_s = '0;
    end else begin
      cur_row_s = row_q;
      cur_col_s = col_q;
    end
  end

  // Raster counters advance once per accepted pixel and wrap at frame end.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept_s) begin
      if (cur_col_s == COL_LAST) begin
        col_d = '0;
        if (cur_row_s == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = cur_row_s + RW'(1);
        end
      end else begin
        col_d = cur_col_s + CW'(1);
        row_d = cur_row_s;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Shift the window one column left and insert {row-2, row-1, new pixel}.
  always_comb begin
    win_d = win_q;
    if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = lb1_rd_s;
      win_d[5] = lb0_rd_s;
      win_d[8] = in_data;
    end else begin
      win_d = win_q;
    end
  end

  // Only positions with two full rows and columns behind them emit a window.
  assign load_s = accept_s && (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));

  // Output register: load a fresh window, drain on ready, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = win_d;
      out_last_d  = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    end else if (win_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign win_valid = out_valid_q;
  assign win_data  = out_data_q;
  assign win_last  = out_last_q;

endmodule

// File: tb/tb_window3x3_gen_fp16.sv
// Directed bench for the 3x3 window generator: a 4x4 instance driven from
// tables of hand-computed windows, plus a default 32x32 instance checked
// against an array-indexed reference.
module tb_window3x3_gen_fp16;
  import acc_pkg::*;

  typedef struct packed { logic last; win9_t w; } wrec_t;
  typedef struct { logic [7:0] e [9]; } woff_t;
  typedef struct { string name; int rdy_mode; int nframes; logic [15:0] base0; logic [15:0] base1; } tcase_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4 instance
  logic        in_valid4 = 1'b0, in_sof4 = 1'b0, win_ready4 = 1'b1;
  logic [15:0] in_data4 = '0;
  logic        in_ready4, win_valid4, win_last4;
  win9_t       win_data4;

  // 32x32 instance
  logic        in_valid32 = 1'b0, in_sof32 = 1'b0, win_ready32 = 1'b1;
  logic [15:0] in_data32 = '0;
  logic        in_ready32, win_valid32, win_last32;
  win9_t       win_data32;

  window3x3_gen_fp16 #(.IMG_W(4), .IMG_H(4), .DATA_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_sof(in_sof4), .win_valid(win_valid4),
    .win_ready(win_ready4), .win_data(win_data4), .win_last(win_last4));

  window3x3_gen_fp16 dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_sof(in_sof32), .win_valid(win_valid32),
    .win_ready(win_ready32), .win_data(win_data32), .win_last(win_last32));

  int    nchecks = 0;
  int    nerrs   = 0;
  int    rdy_mode = 0;       // 0: always ready, 1: toggle, 2: never ready
  woff_t offs [4];
  wrec_t cap4[$], exp4[$], cap32[$], exp32[$];
  logic [15:0] pix [1024];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic win9_t win_of(input logic [15:0] base, input int k);
    win9_t w;
    for (int i = 0; i < 9; i++) w[i] = base + 16'(offs[k].e[i]);
    return w;
  endfunction

  task automatic push_frame4(input logic [15:0] base);
    wrec_t r;
    for (int k = 0; k < 4; k++) begin
      r.w = win_of(base, k);
      r.last = (k == 3);
      exp4.push_back(r);
    end
  endtask

  task automatic cmp4(input string tag);
    chk($sformatf("%s count", tag), 160'(cap4.size()), 160'(exp4.size()));
    for (int i = 0; i < exp4.size() && i < cap4.size(); i++)
      chk($sformatf("%s win%0d", tag, i), 160'(cap4[i]), 160'(exp4[i]));
    cap4.delete();
    exp4.delete();
  endtask

  task automatic send4(input logic [15:0] d, input logic sof);
    int g = 0;
    in_valid4 = 1'b1; in_data4 = d; in_sof4 = sof;
    do begin @(negedge clk); g++; end while (!in_ready4 && g < 200);
    if (!in_ready4) begin
      nchecks++; nerrs++;
      $display("FAIL send4 timeout: in_ready stuck at 0 for pixel %h", d);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_sof4 = 1'b0;
  endtask

  task automatic send32(input logic [15:0] d);
    int g = 0;
    in_valid32 = 1'b1; in_data32 = d;
    do begin @(negedge clk); g++; end while (!in_ready32 && g < 200);
    if (!in_ready32) begin
      nchecks++; nerrs++;
      $display("FAIL send32 timeout: in_ready stuck at 0 for pixel %h", d);
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Ready pattern generator, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       win_ready4 = 1'b1;
      1:       win_ready4 = ~win_ready4;
      2:       win_ready4 = 1'b0;
      default: win_ready4 = 1'b1;
    endcase
    win_ready32 = ($urandom_range(0, 3) != 0);
  end

  // Monitor for the 4x4 instance: capture transfers, check stall stability and in_ready.
  logic  prev_stalled = 1'b0;
  wrec_t held;
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled) begin
        chk("stall valid", 160'(win_valid4), 160'(1'b1));
        chk("stall hold", 160'({win_last4, win_data4}), 160'(held));
      end
      chk("in_ready rule", 160'(in_ready4), 160'(!(win_valid4 && !win_ready4)));
      if (win_valid4 && win_ready4) cap4.push_back({win_last4, win_data4});
      prev_stalled = win_valid4 && !win_ready4;
      held = {win_last4, win_data4};
    end
  end

  // Monitor for the 32x32 instance.
  always @(negedge clk) begin
    if (!rst && win_valid32 && win_ready32) cap32.push_back({win_last32, win_data32});
  end

  tcase_t cases [2];

  initial begin
    // Window offsets within a 4x4 frame, row-major a[3*r+c].
    offs[0].e = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    offs[1].e = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    offs[2].e = '{8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    offs[3].e = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    cases[0] = '{name: "stall", rdy_mode: 1, nframes: 1, base0: 16'h0000, base1: 16'h0000};
    cases[1] = '{name: "b2b",   rdy_mode: 0, nframes: 2, base0: 16'h0000, base1: 16'h0100};

    // Reset state
    #2;
    chk("rst valid", 160'(win_valid4), 160'(1'b0));
    chk("rst last", 160'(win_last4), 160'(1'b0));
    chk("rst data", 160'(win_data4), 160'(0));
    chk("rst in_ready", 160'(in_ready4), 160'(1'b1));
    chk("rst valid32", 160'(win_valid32), 160'(1'b0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame with latency check
    for (int i = 0; i < 16; i++) begin
      send4(16'(i), 1'b0);
      if (i == 9) chk("lat before", 160'(win_valid4), 160'(1'b0));
      if (i == 10) begin
        chk("lat valid", 160'(win_valid4), 160'(1'b1));
        chk("lat data", 160'(win_data4), 160'(win_of(16'h0000, 0)));
      end
    end
    drain();
    push_frame4(16'h0000);
    cmp4("basic");

    // Table-driven cases
    foreach (cases[t]) begin
      rdy_mode = cases[t].rdy_mode;
      @(posedge clk); #1;
      for (int f = 0; f < cases[t].nframes; f++)
        for (int i = 0; i < 16; i++)
          send4(((f == 0) ? cases[t].base0 : cases[t].base1) + 16'(i), 1'b0);
      drain();
      for (int f = 0; f < cases[t].nframes; f++)
        push_frame4((f == 0) ? cases[t].base0 : cases[t].base1);
      cmp4(cases[t].name);
    end
    rdy_mode = 0;
    @(posedge clk); #1;

    // Start-of-frame on the 7th pixel restarts the frame
    for (int i = 0; i < 6; i++) send4(16'h0A00 + 16'(i), 1'b0);
    for (int i = 0; i < 16; i++) send4(16'h0200 + 16'(i), (i == 0));
    drain();
    push_frame4(16'h0200);
    cmp4("sof");

    // Reset while a window is held and stalled
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i <= 10; i++) send4(16'h0500 + 16'(i), 1'b0);
    @(posedge clk); #1;
    chk("pre-rst held", 160'(win_valid4), 160'(1'b1));
    chk("pre-rst in_ready", 160'(in_ready4), 160'(1'b0));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async rst valid", 160'(win_valid4), 160'(1'b0));
    chk("async rst data", 160'(win_data4), 160'(0));
    chk("async rst in_ready", 160'(in_ready4), 160'(1'b1));
    @(posedge clk); #3;
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    cap4.delete();
    for (int i = 0; i < 16; i++) send4(16'h0300 + 16'(i), 1'b0);
    drain();
    push_frame4(16'h0300);
    cmp4("post-rst");

    // Default 32x32 with random data and random downstream ready
    for (int i = 0; i < 1024; i++) pix[i] = 16'($urandom());
    for (int r = 2; r < 32; r++)
      for (int c = 2; c < 32; c++) begin
        wrec_t e;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[3*i + j] = pix[(r - 2 + i) * 32 + (c - 2 + j)];
        e.last = (r == 31) && (c == 31);
        exp32.push_back(e);
      end
    for (int i = 0; i < 1024; i++) send32(pix[i]);
    repeat (40) @(posedge clk);
    #1;
    chk("f32 count", 160'(cap32.size()), 160'(900));
    for (int i = 0; i < exp32.size() && i < cap32.size(); i++)
      chk($sformatf("f32 win%0d", i), 160'(cap32[i]), 160'(exp32[i]));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
